// File: rtl/rf_write_arbiter_if.sv
`timescale 1ns/1ps
// Purpose: bundles the two writeback request ports and the regfile write port.
// Latency: none (wires only).
// Backpressure: r0/r1 driven by the arbiter; requesters hold v/a/d until ready.
// Ports: v0/a0/d0/r0 pipeline writeback, v1/a1/d1/r1 multi-cycle unit,
//        we3/a3/wd3 regfile write port, starve debug flag.
interface rf_write_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r1;
    logic          we3;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic          starve;

    // Arbiter side.
    modport slave (
        input  v0, a0, d0, v1, a1, d1,
        output r0, r1, we3, a3, wd3, starve
    );

    // Requester / regfile side.
    modport master (
        output v0, a0, d0, v1, a1, d1,
        input  r0, r1, we3, a3, wd3, starve
    );
endinterface

// File: rtl/rf_write_arbiter.sv
`timescale 1ns/1ps
// Purpose: shares the regfile write port between pipeline writeback (port 0) and a multi-cycle unit (port 1).
// Latency: one cycle from accepted request to we3/a3/wd3; regfile commits on the edge after that.
// Backpressure: port 0 wins by default; port 1 is escalated after MAX_WAIT blocked cycles.
// Ports: clk, rst (async active-low), bus (slave modport: v/a/d/r per requester, we3/a3/wd3, starve).
module rf_write_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_write_arbiter_if.slave    bus
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    typedef enum logic {NORMAL, STARVE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;
    logic          r0;
    logic          r1;
    logic          xfer0;
    logic          xfer1;
    logic          we3_q;
    logic [AW-1:0] a3_q;
    logic [DW-1:0] wd3_q;

    // Ready depends only on the other port's valid and the FSM state, so the
    // two grants are mutually exclusive by construction.
    always_comb begin
        r0 = 1'b1;
        r1 = 1'b1;
        if (state == NORMAL) begin
            r0 = 1'b1;
            r1 = ~bus.v0;
        end else begin
            r0 = ~bus.v1;
            r1 = 1'b1;
        end
    end

    assign xfer0 = bus.v0 & r0;
    assign xfer1 = bus.v1 & r1;

    // Blocked-cycle counter for port 1, saturating at MAX_WAIT.
    always_comb begin
        cnt_nxt = cnt;
        if (!bus.v1 || xfer1)
            cnt_nxt = 4'd0;
        else if (!r1 && cnt < MAX_W)
            cnt_nxt = cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= NORMAL;
            cnt   <= 4'd0;
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            cnt <= cnt_nxt;

            // Register 0 writes are accepted but never enabled; a3/wd3 still track them.
            if (xfer0) begin
                we3_q <= |bus.a0;
                a3_q  <= bus.a0;
                wd3_q <= bus.d0;
            end else if (xfer1) begin
                we3_q <= |bus.a1;
                a3_q  <= bus.a1;
                wd3_q <= bus.d1;
            end else begin
                we3_q <= 1'b0;
            end

            case (state)
                NORMAL: if (cnt_nxt == MAX_W) state <= STARVE;
                STARVE: if (!bus.v1 || xfer1) state <= NORMAL;
                default: state <= NORMAL;
            endcase
        end
    end

    assign bus.r0     = r0;
    assign bus.r1     = r1;
    assign bus.we3    = we3_q;
    assign bus.a3     = a3_q;
    assign bus.wd3    = wd3_q;
    assign bus.starve = (state == STARVE);

endmodule

// File: tb/tb_rf_write_arbiter.sv
`timescale 1ns/1ps
// Purpose: directed self-checking bench for rf_write_arbiter with a small regfile model.
// Latency: checks outputs 1ns after each rising edge, ready signals 1ns after input changes.
// Backpressure: exercised via starvation escalation and same-address conflict vectors.
module tb_rf_write_arbiter;

    logic clk;
    logic rst;
    int   errs;
    int   nchk;
    logic [31:0] rf [32];

    rf_write_arbiter_if #(.DW(32), .AW(5)) bus ();

    rf_write_arbiter #(.DW(32), .AW(5), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference regfile: commits whatever the arbiter presents.
    always @(posedge clk)
        if (bus.we3) rf[bus.a3] <= bus.wd3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        errs = 0;
        nchk = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;

        // Reset held with both requesters active.
        rst    = 1'b0;
        bus.v0 = 1'b1; bus.a0 = 5'd3;  bus.d0 = 32'hDEAD0003;
        bus.v1 = 1'b1; bus.a1 = 5'd7;  bus.d1 = 32'hBEEF0007;
        tick();
        tick();
        check("rst_we3", {31'd0, bus.we3}, 32'd0);
        check("rst_a3", {27'd0, bus.a3}, 32'd0);
        check("rst_wd3", bus.wd3, 32'd0);
        check("rst_starve", {31'd0, bus.starve}, 32'd0);

        rst = 1'b1;
        settle();
        check("rel_r0", {31'd0, bus.r0}, 32'd1);
        check("rel_r1", {31'd0, bus.r1}, 32'd0);
        tick();
        bus.v0 = 1'b0; bus.v1 = 1'b0;
        check("rel_we3", {31'd0, bus.we3}, 32'd1);
        check("rel_a3", {27'd0, bus.a3}, 32'd3);
        check("rel_wd3", bus.wd3, 32'hDEAD0003);
        tick();
        check("idle_we3", {31'd0, bus.we3}, 32'd0);

        // Single port 0 write.
        bus.v0 = 1'b1; bus.a0 = 5'd8; bus.d0 = 32'hFFFFFFFF;
        settle();
        check("p0_r0", {31'd0, bus.r0}, 32'd1);
        tick();
        bus.v0 = 1'b0;
        check("p0_we3", {31'd0, bus.we3}, 32'd1);
        check("p0_a3", {27'd0, bus.a3}, 32'd8);
        check("p0_wd3", bus.wd3, 32'hFFFFFFFF);
        tick();
        check("p0_rf8", rf[8], 32'hFFFFFFFF);
        check("p0_we3_off", {31'd0, bus.we3}, 32'd0);
        check("p0_a3_hold", {27'd0, bus.a3}, 32'd8);

        // Starvation escalation: port 0 streams, port 1 blocked for 4 cycles.
        bus.v0 = 1'b1; bus.a0 = 5'd1;  bus.d0 = 32'h00000011;
        bus.v1 = 1'b1; bus.a1 = 5'd10; bus.d1 = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("stv_r1_%0d", i), {31'd0, bus.r1}, 32'd0);
            check($sformatf("stv_starve_%0d", i), {31'd0, bus.starve}, 32'd0);
            tick();
        end
        check("stv_starve", {31'd0, bus.starve}, 32'd1);
        check("stv_r1", {31'd0, bus.r1}, 32'd1);
        check("stv_r0", {31'd0, bus.r0}, 32'd0);
        check("stv_a3_p0", {27'd0, bus.a3}, 32'd1);
        tick();
        bus.v1 = 1'b0;
        check("stv_we3", {31'd0, bus.we3}, 32'd1);
        check("stv_a3", {27'd0, bus.a3}, 32'd10);
        check("stv_wd3", bus.wd3, 32'h12345678);
        check("stv_back", {31'd0, bus.starve}, 32'd0);
        settle();
        check("stv_r0_resume", {31'd0, bus.r0}, 32'd1);
        tick();
        bus.v0 = 1'b0;
        check("stv_p0_a3", {27'd0, bus.a3}, 32'd1);
        check("stv_p0_wd3", bus.wd3, 32'h00000011);
        tick();
        check("stv_rf10", rf[10], 32'h12345678);

        // Register 0 write: accepted, never enabled.
        bus.v0 = 1'b1; bus.a0 = 5'd0; bus.d0 = 32'hFFFFFFFF;
        settle();
        check("r0w_r0", {31'd0, bus.r0}, 32'd1);
        tick();
        bus.v0 = 1'b0;
        check("r0w_we3", {31'd0, bus.we3}, 32'd0);
        check("r0w_a3", {27'd0, bus.a3}, 32'd0);
        check("r0w_wd3", bus.wd3, 32'hFFFFFFFF);
        tick();
        check("r0w_rf0", rf[0], 32'h0);

        // Same address on both ports.
        bus.v0 = 1'b1; bus.a0 = 5'd5; bus.d0 = 32'h0000000A;
        bus.v1 = 1'b1; bus.a1 = 5'd5; bus.d1 = 32'h0000000B;
        settle();
        check("same_r0", {31'd0, bus.r0}, 32'd1);
        check("same_r1", {31'd0, bus.r1}, 32'd0);
        tick();
        bus.v0 = 1'b0;
        check("same_wd3_a", bus.wd3, 32'h0000000A);
        check("same_a3_a", {27'd0, bus.a3}, 32'd5);
        settle();
        check("same_r1_go", {31'd0, bus.r1}, 32'd1);
        tick();
        bus.v1 = 1'b0;
        check("same_we3_b", {31'd0, bus.we3}, 32'd1);
        check("same_wd3_b", bus.wd3, 32'h0000000B);
        tick();
        check("same_rf5", rf[5], 32'h0000000B);

        // Async reset 3ps after an accepting edge.
        bus.v0 = 1'b1; bus.a0 = 5'd9; bus.d0 = 32'h0000CAFE;
        @(posedge clk);
        #0.003;
        rst    = 1'b0;
        bus.v0 = 1'b0;
        #0.001;
        check("arst_we3", {31'd0, bus.we3}, 32'd0);
        check("arst_a3", {27'd0, bus.a3}, 32'd0);
        check("arst_wd3", bus.wd3, 32'd0);
        tick();
        check("arst_rf9", rf[9], 32'h0);
        rst = 1'b1;
        tick();
        check("arst_idle_we3", {31'd0, bus.we3}, 32'd0);
        check("arst_rf9_after", rf[9], 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (we3/a3/wd3) between two writeback requesters. Port 0 is pipeline writeback; port 1 is the multi-cycle unit (mul/div or late load return).
- Fixed priority to port 0, with an anti-starvation escalation for port 1.
- Registered output stage directly drives regfile we3/a3/wd3. Sits between the writeback stage and the regfile.

Parameters:
- DW, 32, data width (matches wd3)
- AW, 5, register address width (matches a3)
- MAX_WAIT, 4, consecutive blocked cycles of port 1 before it is escalated to priority (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- v0  in  1  port 0 write request valid
- a0  in  AW  port 0 destination register
- d0  in  DW  port 0 write data
- r0  out  1  port 0 ready (combinational)
- v1  in  1  port 1 write request valid
- a1  in  AW  port 1 destination register
- d1  in  DW  port 1 write data
- r1  out  1  port 1 ready (combinational)
- we3  out  1  regfile write enable (registered)
- a3  out  AW  regfile write address (registered)
- wd3  out  DW  regfile write data (registered)
- starve  out  1  high while FSM in STARVE (debug/perf)

Behaviour:
- Reset (rst=0, async): we3=0, a3=0, wd3=0, wait counter=0, FSM=NORMAL, starve=0. Takes effect immediately, not on the next edge.
- Handshake:
  - Transfer on port k occurs at a rising edge with vk=1 and rk=1.
  - At most one transfer per cycle.
  - A requester holds vk/ak/dk stable until accepted. Arbiter behaviour is undefined if it does not.
- FSM states:
  - NORMAL: r0=1; r1=~v0.
  - STARVE: r1=1; r0=~v1.
- Wait counter (4 bits, saturating at MAX_WAIT):
  - Increments each edge with v1=1 and r1=0.
  - Clears on a port-1 transfer or when v1=0.
- Transitions:
  - NORMAL→STARVE at the edge where the counter reaches MAX_WAIT.
  - STARVE→NORMAL at the edge of the port-1 transfer.
  - STARVE→NORMAL if v1 drops, counter cleared.
- Output stage (one-cycle latency), at each edge:
  - If a transfer occurs: a3<=ak, wd3<=dk, we3<=(ak!=0).
  - Otherwise: we3<=0, a3/wd3 hold.
  - The regfile commits on the following edge.
- Register 0 writes: accepted normally (rk, counter, FSM unaffected) but produce we3=0, so r0 is never written. a3/wd3 still update.
- Same address on both ports in one cycle: only the winner transfers. The loser is written on a later cycle, so the later write wins in the regfile (program order is the requesters' responsibility).
- Back-to-back transfers every cycle are allowed. we3 stays high continuously.
- Reset mid-operation: any in-flight registered write is cancelled (we3 forced 0). Pending requests are not remembered.
- No combinational path from any input to we3/a3/wd3. r0/r1 depend only on v0/v1 and FSM state.

Test Plan:
- Reset: hold rst=0 for 2 cycles with v0=v1=1 → we3=0, a3=0, wd3=0, starve=0. Release rst=1 → first grant goes to port 0, and we3=1 one cycle later.
- Single port 0: v0=1, a0=8, d0=32'hFFFFFFFF for one cycle → r0=1. Next cycle we3=1, a3=8, wd3=32'hFFFFFFFF. Regfile rd1 with a1=8 then reads 32'hFFFFFFFF.
- Starvation with MAX_WAIT=4:
  - Stimulus: v0=1 continuously, v1=1, a1=10, d1=32'h12345678.
  - r1=0 for 4 cycles, then starve=1 and r1=1, r0=0.
  - Next cycle: we3=1, a3=10, wd3=32'h12345678.
  - Then starve=0 and port 0 resumes.
- Register 0 drop: v0=1, a0=0, d0=32'hFFFFFFFF → accepted (r0=1), we3 stays 0. A regfile read of r0 returns 0.
- Same-address conflict: both ports target a=5, d0=32'hA, d1=32'hB, no starvation → port 0 writes 32'hA first, port 1 writes 32'hB on the next cycle. Final read of r5=32'hB.
- Async reset mid-write: assert rst=0 3ps after an accepting edge → we3 drops to 0 immediately, without waiting for the next clk edge. No write reaches the regfile.
